// File: rtl/ahb_lite_req_arbiter_if.sv
// AHB-Lite bus bundle between the request arbiter (master side) and a slave.
interface ahb_lite_req_arbiter_if;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_req_arbiter.sv
// Two-requester AHB-Lite master front end: round-robin arbitration, single
// NONSEQ transfers, every bus output registered.
// Optional feature macro AHB_ARB_LOCK_EN adds req_lock[1:0]: a locked owner
// with a new request at completion keeps the bus and drives HMASTLOCK.
module ahb_lite_req_arbiter (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [5:0]  req_size,
`ifdef AHB_ARB_LOCK_EN
    input  logic [1:0]  req_lock,
`endif
    output logic [1:0]  req_grant,
    output logic [1:0]  req_done,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    ahb_lite_req_arbiter_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [3:0] PROT_DEFAULT = 4'b0011;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        owner;
    logic        owner_write;
    logic [31:0] owner_wdata;
    logic        last_grant;
    logic [1:0]  lock_in;

    logic        rr_win;
    logic        issue;
    logic        issue_win;
    logic        complete;
    logic        complete_err;

    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_size;
    logic        sel_write;

`ifdef AHB_ARB_LOCK_EN
    assign lock_in = req_lock;
`else
    assign lock_in = '0;
`endif

    // Round-robin pick: on a tie the requester not granted last wins
    always_comb begin
        if (&req_valid) rr_win = ~last_grant;
        else            rr_win = req_valid[1];
    end

    // Next state and the issue/complete decisions for this cycle
    always_comb begin
        state_nxt    = state;
        issue        = 1'b0;
        issue_win    = rr_win;
        complete     = 1'b0;
        complete_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    issue     = 1'b1;
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.HREADY) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bus.HREADY) begin
                    complete     = 1'b1;
                    complete_err = bus.HRESP;
                    if (!bus.HRESP && (|req_valid)) begin
                        issue     = 1'b1;
                        state_nxt = ST_ADDR;
                        // locked owner with a fresh request keeps the bus
                        if (lock_in[owner] && req_valid[owner]) issue_win = owner;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (bus.HRESP) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                if (bus.HREADY) begin
                    complete     = 1'b1;
                    complete_err = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Fields of the requester being issued this cycle
    always_comb begin
        sel_addr  = issue_win ? req_addr[63:32]  : req_addr[31:0];
        sel_wdata = issue_win ? req_wdata[63:32] : req_wdata[31:0];
        sel_size  = issue_win ? req_size[5:3]    : req_size[2:0];
        sel_write = issue_win ? req_write[1]     : req_write[0];
    end

    // FSM state, owner bookkeeping and requester-side pulses
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            owner_write <= 1'b0;
            owner_wdata <= '0;
            last_grant  <= 1'b1;
            req_grant   <= '0;
            req_done    <= '0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            req_grant <= '0;
            req_done  <= '0;
            if (complete) begin
                req_done <= owner ? 2'b10 : 2'b01;
                rsp_err  <= complete_err;
                if (!complete_err && !owner_write) rsp_rdata <= bus.HRDATA;
            end
            if (issue) begin
                owner       <= issue_win;
                last_grant  <= issue_win;
                owner_write <= sel_write;
                owner_wdata <= sel_wdata;
                req_grant   <= issue_win ? 2'b10 : 2'b01;
            end
        end
    end

    // Registered AHB address/control/data outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bus.HADDR     <= '0;
            bus.HWRITE    <= 1'b0;
            bus.HSIZE     <= '0;
            bus.HBURST    <= BURST_SINGLE;
            bus.HPROT     <= PROT_DEFAULT;
            bus.HTRANS    <= TRANS_IDLE;
            bus.HMASTLOCK <= 1'b0;
            bus.HWDATA    <= '0;
        end else begin
            bus.HBURST <= BURST_SINGLE;
            bus.HPROT  <= PROT_DEFAULT;
            if (issue) begin
                bus.HADDR     <= sel_addr;
                bus.HWRITE    <= sel_write;
                bus.HSIZE     <= sel_size;
                bus.HTRANS    <= TRANS_NONSEQ;
                bus.HMASTLOCK <= lock_in[issue_win];
            end else if ((state == ST_ADDR) && bus.HREADY) begin
                bus.HTRANS    <= TRANS_IDLE;
                bus.HMASTLOCK <= 1'b0;
                if (owner_write) bus.HWDATA <= owner_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_req_arbiter.sv
// Self-checking bench for ahb_lite_req_arbiter: directed scenarios followed by
// randomized requesters and slave, checked against a transfer-level model.
module tb_ahb_lite_req_arbiter;

    logic        HCLK;
    logic        HRESETn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [5:0]  req_size;
    logic [1:0]  req_lock;
    logic [1:0]  req_grant;
    logic [1:0]  req_done;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // transfer-level model: one outstanding transfer, its phase and owner
    bit          m_last;
    bit          m_outst;
    bit          m_apend;
    bit          m_dphase;
    bit          m_errwait;
    bit          cur_owner;
    bit          cur_write;
    bit          cur_lock;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_size;
    logic [31:0] m_rdata;

    // predictions for the coming clock edge
    logic [1:0]  p_grant;
    logic [1:0]  p_done;
    bit          p_err;
    bit          p_compl;
    bit          p_accept;
    bit          p_errstep;
    bit          p_win;
    logic [31:0] p_rdata;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [2:0]  p_size;
    bit          p_write;
    bit          p_lock;

    ahb_lite_req_arbiter_if bus ();

    ahb_lite_req_arbiter dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
`ifdef AHB_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_grant (req_grant),
        .req_done  (req_done),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .bus       (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic load_req(input int i, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] sz, input bit lk);
        if (i == 0) begin
            req_addr[31:0]  = a;
            req_wdata[31:0] = d;
            req_size[2:0]   = sz;
        end else begin
            req_addr[63:32]  = a;
            req_wdata[63:32] = d;
            req_size[5:3]    = sz;
        end
        req_write[i] = wr;
        req_lock[i]  = lk;
        req_valid[i] = 1'b1;
    endtask

    task automatic model_reset();
        m_last    = 1'b1;
        m_outst   = 1'b0;
        m_apend   = 1'b0;
        m_dphase  = 1'b0;
        m_errwait = 1'b0;
        cur_owner = 1'b0;
        cur_write = 1'b0;
        cur_lock  = 1'b0;
        cur_addr  = '0;
        cur_wdata = '0;
        cur_size  = '0;
        m_rdata   = '0;
    endtask

    // Predict the effect of the coming edge from the inputs now applied
    task automatic predict();
        int w;
        p_compl   = m_dphase && bus.HREADY;
        p_err     = p_compl && (m_errwait || bus.HRESP);
        p_done    = p_compl ? (cur_owner ? 2'b10 : 2'b01) : 2'b00;
        p_rdata   = (p_compl && !p_err && !cur_write) ? bus.HRDATA : m_rdata;
        p_accept  = m_apend && bus.HREADY;
        p_errstep = m_dphase && !bus.HREADY && bus.HRESP;
        p_grant   = 2'b00;
        w = 0;
        if ((req_valid != 2'b00) && (!m_outst || (p_compl && !p_err))) begin
            if (p_compl && req_lock[cur_owner] && req_valid[cur_owner]) w = cur_owner ? 1 : 0;
            else if (req_valid == 2'b11) w = m_last ? 0 : 1;
            else w = req_valid[1] ? 1 : 0;
            p_grant = (w == 1) ? 2'b10 : 2'b01;
        end
        p_win   = (w == 1);
        p_addr  = p_win ? req_addr[63:32]  : req_addr[31:0];
        p_wdata = p_win ? req_wdata[63:32] : req_wdata[31:0];
        p_size  = p_win ? req_size[5:3]    : req_size[2:0];
        p_write = req_write[p_win];
        p_lock  = req_lock[p_win];
    endtask

    task automatic settle_and_check();
        check_val("grant", req_grant, p_grant);
        check_val("done", req_done, p_done);
        if (p_compl) check_val("rsp_err", rsp_err, p_err);
        check_val("rsp_rdata", rsp_rdata, p_rdata);
        if (p_accept) begin
            m_apend  = 1'b0;
            m_dphase = 1'b1;
        end
        if (p_errstep) m_errwait = 1'b1;
        if (p_compl) begin
            m_dphase  = 1'b0;
            m_outst   = 1'b0;
            m_errwait = 1'b0;
            m_rdata   = p_rdata;
        end
        if (p_grant != 2'b00) begin
            m_outst   = 1'b1;
            m_apend   = 1'b1;
            m_last    = p_win;
            cur_owner = p_win;
            cur_write = p_write;
            cur_lock  = p_lock;
            cur_addr  = p_addr;
            cur_wdata = p_wdata;
            cur_size  = p_size;
            req_valid[p_win] = 1'b0;
        end
        check_val("htrans", bus.HTRANS, m_apend ? 2'b10 : 2'b00);
        if (m_apend) begin
            check_val("haddr", bus.HADDR, cur_addr);
            check_val("hwrite", bus.HWRITE, cur_write);
            check_val("hsize", bus.HSIZE, cur_size);
        end
        check_val("hmastlock", bus.HMASTLOCK, m_apend ? cur_lock : 1'b0);
        if (m_dphase && cur_write) check_val("hwdata", bus.HWDATA, cur_wdata);
        check_val("hburst_hprot", {bus.HBURST, bus.HPROT}, 7'b000_0011);
    endtask

    task automatic step();
        predict();
        @(posedge HCLK);
        #1;
        settle_and_check();
    endtask

    // Assert reset between edges, check outputs at once, release a cycle later
    task automatic reset_mid_cycle();
        #3;
        HRESETn = 1'b0;
        #1;
        check_val("rst_haddr", bus.HADDR, 32'h0);
        check_val("rst_hwdata", bus.HWDATA, 32'h0);
        check_val("rst_ctrl",
                  {bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK},
                  {2'b00, 1'b0, 3'b000, 3'b000, 4'b0011, 1'b0});
        check_val("rst_rsp", {req_grant, req_done, rsp_err}, 5'b0);
        check_val("rst_rdata", rsp_rdata, 32'h0);
        model_reset();
        req_valid  = '0;
        req_lock   = '0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    task automatic drive_random();
        bit lk;
        for (int i = 0; i < 2; i++) begin
            if (!req_valid[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    lk = 1'b0;
`ifdef AHB_ARB_LOCK_EN
                    lk = ($urandom_range(0, 2) == 0);
`endif
                    load_req(i, $urandom_range(0, 1) == 1, $urandom, $urandom,
                             3'($urandom_range(0, 2)), lk);
                end
            end else if ($urandom_range(0, 40) == 0) begin
                req_valid[i] = 1'b0;
            end
        end
        if (m_errwait) begin
            bus.HREADY = 1'b1;
            bus.HRESP  = 1'b1;
        end else if (m_dphase) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin bus.HREADY = 1'b1; bus.HRESP = 1'b0; end
                6, 7, 8:          begin bus.HREADY = 1'b0; bus.HRESP = 1'b0; end
                default:          begin bus.HREADY = 1'b0; bus.HRESP = 1'b1; end
            endcase
        end else begin
            bus.HREADY = ($urandom_range(0, 4) != 0);
            bus.HRESP  = 1'b0;
        end
        bus.HRDATA = $urandom;
    endtask

    initial begin
        HRESETn    = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_size   = '0;
        req_lock   = '0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = '0;
        model_reset();
        @(posedge HCLK);
        #1;
        reset_mid_cycle();

        // both requesters on the same cycle after reset: requester 0 first
        load_req(0, 1'b0, 32'h10, 32'h0, 3'd2, 1'b0);
        load_req(1, 1'b0, 32'h20, 32'h0, 3'd2, 1'b0);
        bus.HRDATA = 32'hA0A0_0010;
        step();
        check_val("tie_grant0", req_grant, 2'b01);
        check_val("tie_haddr0", bus.HADDR, 32'h10);
        step();
        check_val("tie_trans_idle", bus.HTRANS, 2'b00);
        step();
        check_val("tie_grant1", req_grant, 2'b10);
        check_val("tie_done0", req_done, 2'b01);
        check_val("tie_rdata0", rsp_rdata, 32'hA0A0_0010);
        check_val("tie_haddr1", bus.HADDR, 32'h20);
        bus.HRDATA = 32'hB0B0_0020;
        step();
        step();
        check_val("tie_done1", req_done, 2'b10);
        check_val("tie_rdata1", rsp_rdata, 32'hB0B0_0020);

        // single uncontended write, zero wait states
        load_req(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'd2, 1'b0);
        step();
        check_val("wr_nonseq", {bus.HTRANS, bus.HWRITE, bus.HSIZE}, {2'b10, 1'b1, 3'd2});
        check_val("wr_haddr", bus.HADDR, 32'h100);
        step();
        check_val("wr_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
        check_val("wr_trans_idle", bus.HTRANS, 2'b00);
        check_val("wr_no_done_yet", req_done, 2'b00);
        step();
        check_val("wr_done", req_done, 2'b01);
        check_val("wr_err", rsp_err, 1'b0);

        // read with three data-phase wait states
        load_req(0, 1'b0, 32'h40, 32'h0, 3'd2, 1'b0);
        step();
        step();
        bus.HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("rdwait_trans", bus.HTRANS, 2'b00);
            check_val("rdwait_done", req_done, 2'b00);
        end
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'h1234_5678;
        step();
        check_val("rdwait_done_pulse", req_done, 2'b01);
        check_val("rdwait_rdata", rsp_rdata, 32'h1234_5678);

        // two-cycle ERROR response on a write; no grant on the error-done edge
        load_req(1, 1'b1, 32'h80, 32'hCAFE_F00D, 3'd2, 1'b0);
        step();
        step();
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        step();
        check_val("err_trans", bus.HTRANS, 2'b00);
        bus.HREADY = 1'b1;
        load_req(0, 1'b0, 32'hC0, 32'h0, 3'd2, 1'b0);
        step();
        check_val("err_done", req_done, 2'b10);
        check_val("err_flag", rsp_err, 1'b1);
        check_val("err_no_grant", req_grant, 2'b00);
        check_val("err_rdata_held", rsp_rdata, 32'h1234_5678);
        bus.HRESP = 1'b0;
        step();
        check_val("err_next_grant", req_grant, 2'b01);
        step();
        step();

        // reset while the address phase is being stretched
        load_req(0, 1'b0, 32'h200, 32'h0, 3'd2, 1'b0);
        step();
        bus.HREADY = 1'b0;
        step();
        check_val("addrwait_haddr", bus.HADDR, 32'h200);
        reset_mid_cycle();
        step();
        step();
        load_req(0, 1'b0, 32'h210, 32'h0, 3'd1, 1'b0);
        load_req(1, 1'b1, 32'h220, 32'h5555_AAAA, 3'd0, 1'b0);
        step();
        check_val("postrst_grant0", req_grant, 2'b01);
        for (int k = 0; k < 4; k++) step();

`ifdef AHB_ARB_LOCK_EN
        begin
            int  g0;
            bit  got1;
            bit  seen_lock;
            g0 = 0;
            got1 = 1'b0;
            seen_lock = 1'b0;
            load_req(1, 1'b0, 32'h300, 32'h0, 3'd2, 1'b0);
            load_req(0, 1'b1, 32'h400, 32'h1111_0000, 3'd2, 1'b1);
            for (int k = 0; k < 40 && !got1; k++) begin
                step();
                if (req_grant[0]) begin
                    g0++;
                    if (bus.HMASTLOCK) seen_lock = 1'b1;
                    if (g0 < 3) load_req(0, 1'b1, 32'h400 + 32'(g0 * 4), 32'h1111_0000 + 32'(g0), 3'd2, 1'b1);
                end
                if (req_grant[1]) got1 = 1'b1;
            end
            check_val("lock_grants0", g0, 3);
            check_val("lock_mastlock", seen_lock, 1'b1);
            check_val("lock_then_req1", got1, 1'b1);
            step();
            step();
        end
`endif

        // randomized requesters and slave
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
